// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant bundle between the AHB masters and the bus arbiter.
// The arbiter attaches through the slave modport; the master side drives requests.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 3
);
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [1:0]             hmaster;
    logic [1:0]             hmaster_d;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hready,
        input  hgrant, hmaster, hmaster_d, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hready,
        output hgrant, hmaster, hmaster_d, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with lock support, burst protection and a per-tenure
// beat cap; also tracks address-phase and data-phase owner indices.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_BEATS      = 16
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    ahb_bus_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {PARK, OWNED, LOCKED} state_t;

    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    state_t                 state;
    logic [1:0]             owner;
    logic [7:0]             beat_cnt;

    logic                   own_req, own_lock, others_req, any_req;
    logic                   ap, preempt, rearb, found;
    logic [1:0]             win;
    logic [NUM_MASTERS-1:0] grant_win;

    assign own_req    = |(bus.hbusreq & bus.hgrant);
    assign own_lock   = |(bus.hlock & bus.hgrant);
    assign others_req = |(bus.hbusreq & ~bus.hgrant);
    assign any_req    = |bus.hbusreq;

    // IDLE and NONSEQ both have htrans[0]=0; SEQ/BUSY never break a burst.
    assign ap = bus.hready && !bus.htrans[0] && !own_lock;

    // A locked tenure is only measured against the cap once hlock has fallen.
    assign preempt = (state != LOCKED || !own_lock) &&
                     (beat_cnt >= 8'(MAX_BEATS)) && others_req;
    assign rearb   = ap && (!own_req || preempt);

    // Scan owner+1 .. owner (wrapping); owner itself is considered last.
    always_comb begin
        win   = 2'(DEFAULT_MASTER);
        found = 1'b0;
        for (int o = 0; o < NUM_MASTERS; o++) begin
            if (owner == 2'(o)) begin
                for (int i = 1; i <= NUM_MASTERS; i++) begin
                    if (!found && bus.hbusreq[(o + i) % NUM_MASTERS]) begin
                        win   = 2'((o + i) % NUM_MASTERS);
                        found = 1'b1;
                    end
                end
            end
        end
        for (int k = 0; k < NUM_MASTERS; k++)
            grant_win[k] = (win == 2'(k));
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state         <= PARK;
            owner         <= 2'(DEFAULT_MASTER);
            beat_cnt      <= '0;
            bus.hgrant    <= DEF_GRANT;
            bus.hmaster   <= 2'(DEFAULT_MASTER);
            bus.hmaster_d <= 2'(DEFAULT_MASTER);
            bus.hmastlock <= 1'b0;
        end else if (bus.hready) begin
            bus.hmaster   <= owner;
            bus.hmaster_d <= bus.hmaster;
            bus.hmastlock <= own_lock;

            // Tenure length restarts whenever the address-phase owner changes.
            if (owner != bus.hmaster)
                beat_cnt <= '0;
            else if (bus.htrans[1] && beat_cnt != 8'hff)
                beat_cnt <= beat_cnt + 8'd1;

            if (rearb) begin
                owner      <= win;
                bus.hgrant <= grant_win;
                if (!any_req)
                    state <= PARK;
                else if (|(bus.hlock & grant_win))
                    state <= LOCKED;
                else
                    state <= OWNED;
            end else if (own_lock) begin
                state <= LOCKED;
            end else if (own_req) begin
                state <= OWNED;
            end
        end
    end
endmodule
